data_mem_arbiter: RTL and testbench

- Shares the single-port, byte-addressed data memory between two requesters.
  - Port 0: CPU load/store unit.
  - Port 1: debug/DMA loader.
- Round-robin arbitration over a valid/ready request handshake.
- Sequences each transfer through a small FSM.
- Memory only writes full 4-byte words, so byte and halfword stores are done as read-merge-write; load results are sign- or zero-extended.
- Sits between the requesters and data_memory. It drives data_memory's wen/addr/din and consumes its combinational dout.

---
 rtl/data_mem_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/data_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the two-port data memory arbiter:
// access-size encodings, FSM states and requester ids.
package data_mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Request fields captured at the handshake (address kept separately,
  // its width depends on the memory size).
  typedef struct packed {
    logic              wen;
    size_e             size;
    logic              is_unsigned;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment between requesters and the word-wide memory:
// read-merge for narrow stores and sign/zero extension for narrow loads.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [DATA_W-1:0] i_dout,
  input  logic [DATA_W-1:0] i_wdata,
  input  size_e             i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_din,
  output logic [DATA_W-1:0] o_rdata
);

  logic w_sign_b;
  logic w_sign_h;

  assign w_sign_b = ~i_unsigned & i_dout[7];
  assign w_sign_h = ~i_unsigned & i_dout[15];

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    o_din   = i_wdata;
    o_rdata = '0;
    case (i_size)
      SZ_BYTE: begin
        o_din   = {i_dout[31:8], i_wdata[7:0]};
        o_rdata = {{24{w_sign_b}}, i_dout[7:0]};
      end
      SZ_HALF: begin
        o_din   = {i_dout[31:16], i_wdata[15:0]};
        o_rdata = {{16{w_sign_h}}, i_dout[15:0]};
      end
      SZ_WORD: begin
        o_din   = i_wdata;
        o_rdata = i_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-port byte-addressed data memory
// between the CPU LSU (port 0) and the debug/DMA loader (port 1).
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int MEM_SIZE    = 256,
  parameter int ADDR_W      = $clog2(MEM_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_wen,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [1:0]             req0_size,
  input  logic                   req0_unsigned,
  input  logic [DATA_LENGTH-1:0] req0_wdata,
  output logic                   rsp0_valid,
  output logic [DATA_LENGTH-1:0] rsp0_rdata,
  output logic                   rsp0_err,

  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_wen,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [1:0]             req1_size,
  input  logic                   req1_unsigned,
  input  logic [DATA_LENGTH-1:0] req1_wdata,
  output logic                   rsp1_valid,
  output logic [DATA_LENGTH-1:0] rsp1_rdata,
  output logic                   rsp1_err,

  output logic                   mem_wen,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_LENGTH-1:0] mem_din,
  input  logic [DATA_LENGTH-1:0] mem_dout
);

  localparam int CHK_W = ADDR_W + 3;

  state_e                 r_state;
  state_e                 w_next;
  logic                   r_prio;
  logic                   r_id;
  logic [ADDR_W-1:0]      r_addr;
  req_t                   r_req;
  logic [DATA_LENGTH-1:0] r_rdata;
  logic                   r_err;
  logic [DATA_LENGTH-1:0] r_mem_din;

  logic                   w_grant0;
  logic                   w_grant1;
  logic                   w_hs;
  logic                   w_win;
  req_t                   w_req;
  logic [ADDR_W-1:0]      w_addr;
  logic [CHK_W-1:0]       w_end;
  logic                   w_err;
  logic [DATA_LENGTH-1:0] w_merge;
  logic [DATA_LENGTH-1:0] w_extract;

  // A lone requester always wins; on contention prio names the winner.
  assign w_grant0 = req0_valid & (~req1_valid | (r_prio == REQ_CPU));
  assign w_grant1 = req1_valid & (~req0_valid | (r_prio == REQ_DMA));
  assign w_hs     = w_grant0 | w_grant1;
  assign w_win    = w_grant1 ? REQ_DMA : REQ_CPU;

  assign w_addr = w_win ? req1_addr : req0_addr;
  assign w_req  = w_win
                ? '{wen: req1_wen, size: size_e'(req1_size),
                    is_unsigned: req1_unsigned, wdata: req1_wdata}
                : '{wen: req0_wen, size: size_e'(req0_size),
                    is_unsigned: req0_unsigned, wdata: req0_wdata};

  // Widened so an address near the top of memory cannot wrap past the check.
  assign w_end = {3'b000, r_addr} + CHK_W'(4);
  assign w_err = (r_req.size == SZ_ILLEGAL) || (w_end > CHK_W'(MEM_SIZE));

  mem_lane_align u_align (
    .i_dout     (mem_dout),
    .i_wdata    (r_req.wdata),
    .i_size     (r_req.size),
    .i_unsigned (r_req.is_unsigned),
    .o_din      (w_merge),
    .o_rdata    (w_extract)
  );

  assign mem_addr = r_addr;

  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mem_wen    = 1'b0;
    mem_din    = r_mem_din;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_grant0 & ~reset;
        req1_ready = w_grant1 & ~reset;
        if (w_hs) w_next = ACCESS;
      end
      ACCESS: begin
        if (r_req.wen && !w_err) begin
          mem_wen = ~reset;
          mem_din = w_merge;
        end
        w_next = RESP;
      end
      RESP: begin
        rsp0_valid = (r_id == REQ_CPU) & ~reset;
        rsp1_valid = (r_id == REQ_DMA) & ~reset;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign rsp0_rdata = rsp0_valid ? r_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? r_rdata : '0;
  assign rsp0_err   = rsp0_valid & r_err;
  assign rsp1_err   = rsp1_valid & r_err;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_prio    <= REQ_CPU;
      r_id      <= REQ_CPU;
      r_addr    <= '0;
      r_req     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_mem_din <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_hs) begin
        r_addr <= w_addr;
        r_req  <= w_req;
        r_id   <= w_win;
        r_prio <= ~w_win;
      end
      if (r_state == ACCESS) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_req.wen) ? '0 : w_extract;
        if (mem_wen) r_mem_din <= mem_din;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, reset and
// contention sequences, then random traffic against a byte-array model.
module tb_data_mem_arbiter;

  localparam int MS = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_clear = 1'b1;

  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_wen = '0;
  logic [1:0]  req_uns = '0;
  logic [1:0]  req_size [2];
  logic [7:0]  req_addr [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_err;
  logic [31:0] rsp_rdata [2];

  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int n_checks = 0;
  int n_err = 0;

  data_mem_arbiter #(.DATA_LENGTH(32), .MEM_SIZE(MS)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req_valid[0]),
    .req0_ready    (req_ready[0]),
    .req0_wen      (req_wen[0]),
    .req0_addr     (req_addr[0]),
    .req0_size     (req_size[0]),
    .req0_unsigned (req_uns[0]),
    .req0_wdata    (req_wdata[0]),
    .rsp0_valid    (rsp_valid[0]),
    .rsp0_rdata    (rsp_rdata[0]),
    .rsp0_err      (rsp_err[0]),
    .req1_valid    (req_valid[1]),
    .req1_ready    (req_ready[1]),
    .req1_wen      (req_wen[1]),
    .req1_addr     (req_addr[1]),
    .req1_size     (req_size[1]),
    .req1_unsigned (req_uns[1]),
    .req1_wdata    (req_wdata[1]),
    .rsp1_valid    (rsp_valid[1]),
    .rsp1_rdata    (rsp_rdata[1]),
    .rsp1_err      (rsp_err[1]),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout)
  );

  always #5 clk = ~clk;

  // Memory fixture: byte array, combinational little-endian word read.
  logic [7:0] fmem [MS];
  int         wr_count = 0;

  assign mem_dout = {fmem[8'(mem_addr + 8'd3)], fmem[8'(mem_addr + 8'd2)],
                     fmem[8'(mem_addr + 8'd1)], fmem[mem_addr]};

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MS; i++) fmem[i] <= 8'h00;
    end else if (mem_wen) begin
      for (int k = 0; k < 4; k++) fmem[8'(mem_addr + 8'(k))] <= mem_din[8*k +: 8];
      wr_count <= wr_count + 1;
    end
  end

  // Reference model: memory as bytes, accesses touch exactly size bytes.
  logic [7:0] ref_mem [MS];

  task automatic model(input logic wen, input logic [7:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
    int      n;
    longint  v;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    err = (size == 2'b11) || (int'(addr) + 4 > MS);
    rdata = '0;
    if (!err) begin
      if (wen) begin
        for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v + longint'(ref_mem[int'(addr) + i]) * (longint'(1) << (8 * i));
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        rdata = 32'(v);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One transfer on port p, starting just after a posedge with the DUT idle.
  task automatic xfer(input int p, input logic wen, input logic [7:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic er, output int nwr);
    int w0;
    w0 = wr_count;
    req_wen[p] = wen; req_addr[p] = addr; req_size[p] = size;
    req_uns[p] = uns; req_wdata[p] = wdata; req_valid[p] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[p]) break;
    end
    check("ready", 32'(req_ready), 32'(2'b01 << p));
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    @(negedge clk);
    check("access_quiet", {28'd0, rsp_valid, req_ready}, 32'd0);
    @(negedge clk);
    check("rsp_latency", 32'(rsp_valid), 32'(2'b01 << p));
    rd = rsp_rdata[p];
    er = rsp_err[p];
    @(posedge clk); #1;
    nwr = wr_count - w0;
  endtask

  typedef struct {
    int          port;
    logic        wen;
    logic [7:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;
    int          nwr, w0, nbad, ngrant, nrsp;
    int          grants [4];
    int          rsps [4];
    logic [31:0] exp_c [2];
    logic        dropped;
    logic [1:0]  sz;
    logic [7:0]  ad;

    for (int i = 0; i < MS; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      req_size[i] = 2'b00; req_addr[i] = 8'h00; req_wdata[i] = 32'h0;
    end

    //          port wen addr   size   uns  wdata          rdata          err
    vecs[0]  = '{0, 1'b1, 8'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{0, 1'b0, 8'h10, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1, 1'b1, 8'h20, 2'b10, 1'b0, 32'h11223344, 32'h00000000, 1'b0};
    vecs[3]  = '{1, 1'b1, 8'h20, 2'b00, 1'b0, 32'h555555AA, 32'h00000000, 1'b0};
    vecs[4]  = '{0, 1'b0, 8'h20, 2'b10, 1'b0, 32'h0,        32'h112233AA, 1'b0};
    vecs[5]  = '{1, 1'b0, 8'h20, 2'b00, 1'b0, 32'h0,        32'hFFFFFFAA, 1'b0};
    vecs[6]  = '{1, 1'b0, 8'h20, 2'b00, 1'b1, 32'h0,        32'h000000AA, 1'b0};
    vecs[7]  = '{0, 1'b1, 8'h22, 2'b01, 1'b0, 32'hABCD8001, 32'h00000000, 1'b0};
    vecs[8]  = '{0, 1'b0, 8'h22, 2'b01, 1'b0, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[9]  = '{0, 1'b0, 8'h22, 2'b01, 1'b1, 32'h0,        32'h00008001, 1'b0};
    vecs[10] = '{0, 1'b0, 8'h21, 2'b10, 1'b0, 32'h0,        32'h00800133, 1'b0};
    vecs[11] = '{1, 1'b1, 8'd253, 2'b10, 1'b0, 32'h12345678, 32'h00000000, 1'b1};
    vecs[12] = '{1, 1'b1, 8'd252, 2'b10, 1'b0, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[13] = '{0, 1'b0, 8'd252, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[14] = '{0, 1'b0, 8'h10, 2'b11, 1'b0, 32'h0,        32'h00000000, 1'b1};
    vecs[15] = '{1, 1'b1, 8'h10, 2'b11, 1'b0, 32'h99999999, 32'h00000000, 1'b1};
    vecs[16] = '{0, 1'b0, 8'd255, 2'b00, 1'b1, 32'h0,       32'h00000000, 1'b1};
    vecs[17] = '{0, 1'b0, 8'h13, 2'b00, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rdata0", rsp_rdata[0], 32'd0);
    check("rst_rdata1", rsp_rdata[1], 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_clear = 1'b0;

    // Directed vectors.
    foreach (vecs[i]) begin
      model(vecs[i].wen, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, mrd, mer);
      xfer(vecs[i].port, vecs[i].wen, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
           rd, er, nwr);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_writes", i), nwr, (vecs[i].wen && !vecs[i].exp_err) ? 1 : 0);
    end

    // Reset during ACCESS of a store to 0x40: the store must be dropped.
    w0 = wr_count;
    req_wen[0] = 1'b1; req_addr[0] = 8'h40; req_size[0] = 2'b10;
    req_uns[0] = 1'b0; req_wdata[0] = 32'h12345678; req_valid[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[0]) break;
    end
    check("rmid_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rmid_no_wen", 32'(mem_wen), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rmid_ready_rst", 32'(req_ready), 32'd0);
    check("rmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rmid_rsp_err", 32'(rsp_err), 32'd0);
    check("rmid_rdata", rsp_rdata[0] | rsp_rdata[1], 32'd0);
    check("rmid_mem_addr", 32'(mem_addr), 32'd0);
    check("rmid_mem_din", mem_din, 32'd0);
    check("rmid_writes", wr_count - w0, 32'd0);
    check("rmid_word40", {fmem[8'h43], fmem[8'h42], fmem[8'h41], fmem[8'h40]}, 32'd0);

    // Contention from reset: both valid continuously, grants alternate from 0.
    req_wen = 2'b00; req_uns = 2'b00;
    req_addr[0] = 8'h10; req_size[0] = 2'b10;
    req_addr[1] = 8'd252; req_size[1] = 2'b10;
    model(1'b0, 8'h10, 2'b10, 1'b0, 32'h0, exp_c[0], mer);
    model(1'b0, 8'd252, 2'b10, 1'b0, 32'h0, exp_c[1], mer);
    req_valid = 2'b11;
    @(negedge clk);
    check("cont_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ngrant = 0; nrsp = 0; dropped = 1'b0;
    for (int i = 0; i < 4; i++) begin grants[i] = -1; rsps[i] = -1; end
    for (int cyc = 0; cyc < 60 && nrsp < 4; cyc++) begin
      @(negedge clk);
      check("cont_excl", 32'((req_ready == 2'b11) || (rsp_valid == 2'b11)), 32'd0);
      if (req_ready != 2'b00 && ngrant < 4) begin
        grants[ngrant] = req_ready[1] ? 1 : 0;
        ngrant++;
      end
      if (rsp_valid != 2'b00 && nrsp < 4) begin
        rsps[nrsp] = rsp_valid[1] ? 1 : 0;
        check("cont_rdata", rsp_rdata[rsps[nrsp]], exp_c[rsps[nrsp]]);
        nrsp++;
      end
      if (ngrant == 4 && !dropped) begin
        @(posedge clk); #1;
        req_valid = 2'b00;
        dropped = 1'b1;
      end
    end
    req_valid = 2'b00;
    check("cont_nrsp", nrsp, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_grant%0d", i), grants[i], i % 2);
      check($sformatf("cont_rsp%0d", i), rsps[i], i % 2);
    end
    @(posedge clk); #1;

    // Random traffic against the model.
    for (int t = 0; t < 80; t++) begin
      int p;
      logic wen, uns;
      logic [31:0] wd;
      p   = int'($urandom_range(0, 1));
      wen = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      ad  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 63));
      wd  = $urandom;
      model(wen, ad, sz, uns, wd, mrd, mer);
      xfer(p, wen, ad, sz, uns, wd, rd, er, nwr);
      check($sformatf("rnd%0d_rdata", t), rd, mrd);
      check($sformatf("rnd%0d_err", t), 32'(er), 32'(mer));
      check($sformatf("rnd%0d_writes", t), nwr, (wen && !mer) ? 1 : 0);
    end

    nbad = 0;
    for (int i = 0; i < MS; i++) if (fmem[i] !== ref_mem[i]) nbad++;
    check("mem_image", nbad, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
